trng_sampler: RTL



---
 rtl/trng_pkg.sv | 9 +
 rtl/trng_sync2.sv | 14 +
 rtl/trng_sampler.sv | 78 +++++++
 3 files changed

// File: rtl/trng_pkg.sv
// trng_pkg: shared FSM state type and default sizing for the TRNG sampler.
package trng_pkg;
    typedef enum logic [1:0] {IDLE, EXCITE, EVAL, SAMPLE} trng_state_e;
    localparam int WORD_W_DEF     = 32;
    localparam int EXCITE_CYC_DEF = 4;
    localparam int SETTLE_CYC_DEF = 8;
    localparam int CNT_W          = 6;
    localparam int PH_W           = 16;
endpackage

// File: rtl/trng_sync2.sv
// trng_sync2: parameterised-width two-flop synchronizer with synchronous reset.
module trng_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk)
        if (rst) {q, meta} <= '0;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/trng_sampler.sv
// trng_sampler: entropy cell excitation FSM, XOR reduction and 32-bit word packer.
// Define TRNG_VON_NEUMANN_EN to debias raw bits in (first, second) pairs.
module trng_sampler
    import trng_pkg::*;
#(
    parameter int N_CELLS    = 8,
    parameter int WORD_W     = WORD_W_DEF,
    parameter int EXCITE_CYC = EXCITE_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    output logic               cell_T_o,
    output logic               cell_I1_o,
    output logic               cell_I2_o,
    input  logic [N_CELLS-1:0] cell_entropy_i,
    output logic [WORD_W-1:0]  rnd_data_o,
    output logic               rnd_valid_o,
    input  logic               rnd_ready_i,
    output logic               busy_o
);
    trng_state_e state, state_n;
    logic [PH_W-1:0] ph;
    logic [N_CELLS-1:0] sync_q;
    logic [WORD_W-1:0] sr, sr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic take, acc, bit_v, ph_done, load, blocked;
    trng_sync2 #(.W(N_CELLS)) u_sync (.clk(clk), .rst(rst), .d(cell_entropy_i), .q(sync_q));
    assign take = state == SAMPLE;
`ifdef TRNG_VON_NEUMANN_EN
    logic pend, pend_v;
    // Only unequal pairs yield a bit; the pair's first value is the output.
    assign acc   = take && pend && (pend_v != ^sync_q);
    assign bit_v = pend_v;
    always_ff @(posedge clk)
        if (rst) {pend, pend_v} <= '0;
        else if (take) {pend, pend_v} <= {~pend, ^sync_q};
`else
    assign acc   = take;
    assign bit_v = ^sync_q;
`endif
    assign sr_n    = acc ? {sr[WORD_W-2:0], bit_v} : sr;
    assign cnt_n   = cnt + CNT_W'(acc);
    assign load    = cnt_n == CNT_W'(WORD_W) && (!rnd_valid_o || rnd_ready_i);
    assign blocked = cnt_n == CNT_W'(WORD_W) && !load;
    assign ph_done = ph == PH_W'(state == EXCITE ? EXCITE_CYC - 1 : SETTLE_CYC - 1);
    assign cell_I2_o = 1'b0;
    always_comb
        case (state)
            EXCITE:  state_n = !en_i ? IDLE : ph_done ? EVAL : EXCITE;
            EVAL:    state_n = !en_i ? IDLE : ph_done ? SAMPLE : EVAL;
            default: state_n = en_i && !blocked ? EXCITE : IDLE;
        endcase
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ph          <= '0;
            sr          <= '0;
            cnt         <= '0;
            cell_T_o    <= 1'b0;
            cell_I1_o   <= 1'b0;
            rnd_data_o  <= '0;
            rnd_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_n;
            ph          <= state_n == state ? ph + 1'b1 : '0;
            cell_T_o    <= state_n inside {EVAL, SAMPLE};
            cell_I1_o   <= state_n inside {EVAL, SAMPLE};
            busy_o      <= state_n != IDLE;
            sr          <= sr_n;
            cnt         <= load ? '0 : cnt_n;
            rnd_valid_o <= load || (rnd_valid_o && !rnd_ready_i);
            if (load) rnd_data_o <= sr_n;
        end
    end
endmodule
